// File: rtl/id_operand_fetch.sv
// Decode/operand-fetch stage: 32x32 register file, rs/rt read with write-back bypass,
// and a one-deep registered operand bundle to the ALU over a valid/ready handshake.
module id_operand_fetch #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] i_datain,
  output logic [DATA_W-1:0] gr1,
  output logic [DATA_W-1:0] gr2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [31:0]       issue_count
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_datain;
  logic [DATA_W-1:0] r_gr1;
  logic [DATA_W-1:0] r_gr2;
  logic [31:0]       r_issue_count;

  logic              w_accept;
  logic              w_stall;
  logic              w_wb_live;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_held_rs;
  logic [ADDR_W-1:0] w_held_rt;
  logic [DATA_W-1:0] w_rd_rs;
  logic [DATA_W-1:0] w_rd_rt;

  assign w_rs      = in_instr[25:21];
  assign w_rt      = in_instr[20:16];
  assign w_held_rs = r_datain[25:21];
  assign w_held_rt = r_datain[20:16];

  assign in_ready  = !flush && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_stall   = r_out_valid && !out_ready;
  assign w_wb_live = wb_en && (wb_addr != '0);

  // A write-back landing this cycle is visible to the read that issues alongside it.
  assign w_rd_rs = (w_rs == '0)                  ? '0      :
                   (w_wb_live && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
  assign w_rd_rt = (w_rt == '0)                  ? '0      :
                   (w_wb_live && wb_addr == w_rt) ? wb_data : r_regs[w_rt];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_datain      <= '0;
      r_gr1         <= '0;
      r_gr2         <= '0;
      r_issue_count <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wb_live) begin
        r_regs[wb_addr] <= wb_data;
      end

      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A held bundle keeps tracking write-backs to its own rs/rt so it never goes stale.
      if (w_accept) begin
        r_datain <= in_instr;
        r_gr1    <= w_rd_rs;
        r_gr2    <= w_rd_rt;
      end else if (w_stall && w_wb_live) begin
        if (wb_addr == w_held_rs) begin
          r_gr1 <= wb_data;
        end
        if (wb_addr == w_held_rt) begin
          r_gr2 <= wb_data;
        end
      end

      if (r_out_valid && out_ready && !flush) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign i_datain    = r_datain;
  assign gr1         = r_gr1;
  assign gr2         = r_gr2;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Scoreboard bench for id_operand_fetch: a reference model predicts each bundle when
// it is offered and compares it when the DUT presents it.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] i_datain;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [31:0] issue_count;

  id_operand_fetch #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .i_datain(i_datain), .gr1(gr1), .gr2(gr2), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] g1;
    logic [31:0] g2;
  } bundle_t;

  bundle_t     sb_q[$];
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_count;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] lo);
    return {6'h00, rs, rt, lo};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0;
    m_count = 32'h0;
    sb_q.delete();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b1;
    wb_en     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'h0;
    flush     = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances model, returns at next posedge+1.
  task automatic tick();
    logic    exp_rdy;
    logic    acc;
    logic    wb_live;
    bundle_t b;
    #1;
    exp_rdy = !flush && (!m_valid || out_ready);
    acc     = in_valid && exp_rdy;
    wb_live = wb_en && (wb_addr != 5'd0);
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    chk("issue_count", issue_count, m_count);
    if (m_valid) begin
      chk("sb_depth", sb_q.size(), 32'd1);
      if (sb_q.size() > 0) begin
        chk("i_datain", i_datain, sb_q[0].instr);
        chk("gr1", gr1, sb_q[0].g1);
        chk("gr2", gr2, sb_q[0].g2);
      end
    end
    if (!rst_n) begin
      model_clear();
    end else begin
      if (m_valid && out_ready && !flush) m_count++;
      if (m_valid && (out_ready || flush)) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else if (m_valid && wb_live && sb_q.size() > 0) begin
        b = sb_q[0];
        if (wb_addr == b.instr[25:21]) b.g1 = wb_data;
        if (wb_addr == b.instr[20:16]) b.g2 = wb_data;
        sb_q[0] = b;
      end
      if (acc) begin
        b.instr = in_instr;
        b.g1    = m_read(in_instr[25:21]);
        b.g2    = m_read(in_instr[20:16]);
        sb_q.push_back(b);
      end
      m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
      if (wb_live) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1; in_instr = ins;
  endtask

  logic [31:0] base_cnt;

  initial begin
    idle();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    tick();
    chk("rst_issue_count", issue_count, 32'h0);
    rst_n = 1'b1;

    // register write-back, then add r10,r8,r9
    wb(5'd8, 32'h0000_0005); tick();
    wb(5'd9, 32'hFFFF_FFFD); tick();
    idle(); offer(32'h0109_5020); tick();
    chk("t1_gr1", gr1, 32'h0000_0005);
    chk("t1_gr2", gr2, 32'hFFFF_FFFD);
    idle(); tick();
    chk("t1_count", issue_count, 32'd1);
    tick();

    // bypass into a same-cycle read, and r0 stays zero
    offer(mk(5'd3, 5'd8, 16'h0001)); wb(5'd3, 32'h1234_5678); tick();
    chk("t2_bypass", gr1, 32'h1234_5678);
    idle(); tick();
    wb(5'd0, 32'hDEAD_BEEF); tick();
    idle(); offer(mk(5'd0, 5'd3, 16'h0002)); tick();
    chk("t2_r0", gr1, 32'h0);
    idle(); tick();

    // stall with write-back to the held rt
    offer(mk(5'd1, 5'd4, 16'h0003)); tick();
    base_cnt = issue_count;
    idle(); out_ready = 1'b0; offer(mk(5'd2, 5'd2, 16'h0BAD)); tick();
    wb(5'd4, 32'hA5A5_A5A5); tick();
    wb_en = 1'b0; tick();
    chk("t3_gr2_upd", gr2, 32'hA5A5_A5A5);
    chk("t3_instr_hold", i_datain, mk(5'd1, 5'd4, 16'h0003));
    idle(); tick();
    tick();
    chk("t3_count_once", issue_count, base_cnt + 32'd1);

    // back-to-back
    for (int i = 0; i < 4; i++) begin
      offer(mk(5'(i + 8), 5'(i + 9), 16'(i))); tick();
    end
    idle(); tick(); tick();

    // flush with a concurrent offer and write-back
    offer(mk(5'd8, 5'd9, 16'h0004)); tick();
    base_cnt = issue_count;
    flush = 1'b1; offer(mk(5'd5, 5'd5, 16'h0005)); wb(5'd5, 32'h55AA_1234); tick();
    chk("t5_count_hold", issue_count, base_cnt);
    idle(); offer(mk(5'd5, 5'd5, 16'h0006)); tick();
    chk("t5_r5", gr1, 32'h55AA_1234);
    idle(); tick();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      idle();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_addr   = 5'($urandom_range(0, 31));
      wb_data   = $urandom();
      flush     = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle(); tick(); tick();

    // reset during a stall with a write-back
    offer(mk(5'd7, 5'd6, 16'h0007)); tick();
    idle(); out_ready = 1'b0; wb(5'd7, 32'hCAFE_F00D); rst_n = 1'b0; tick();
    chk("t6_count", issue_count, 32'h0);
    chk("t6_valid", {31'h0, out_valid}, 32'h0);
    rst_n = 1'b1; idle();
    for (int k = 0; k < 16; k++) begin
      offer(mk(5'(2 * k), 5'(2 * k + 1), 16'h0)); tick();
    end
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
